// File: rtl/display_scheduler.sv
// Arbitrates A/B/sum display requests by fixed priority and converts the
// granted value to four BCD digits with a sequential double-dabble engine.
module display_scheduler #(
   parameter int unsigned HOLD_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [13:0] op_a,
   input  logic        op_a_req,
   input  logic [13:0] op_b,
   input  logic        op_b_req,
   input  logic [13:0] sum,
   input  logic        sum_req,
   output logic [15:0] bcd_out,
   output logic        bcd_valid,
   output logic [1:0]  src_sel,
   output logic        overflow,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, CONVERT, HOLD} state_t;

   localparam logic [31:0] HOLD_LOAD =
      (HOLD_CYCLES == 0) ? 32'd0 : 32'(HOLD_CYCLES - 1);

   state_t      state, state_nxt;
   logic [2:0]  pend;
   logic [29:0] sreg;
   logic [3:0]  iter;
   logic [1:0]  cur_src;
   logic        cur_ovf;
   logic [31:0] hold_cnt;

   logic        grant;
   logic        done;
   logic [1:0]  gsel;
   logic [13:0] gdata;
   logic [13:0] gclamp;
   logic [2:0]  clr;
   logic [15:0] adj;
   logic [29:0] step;

   // Fixed priority: sum > op_b > op_a
   always_comb begin
      gsel  = 2'd0;
      gdata = op_a;
      if (pend[2]) begin
         gsel  = 2'd2;
         gdata = sum;
      end else if (pend[1]) begin
         gsel  = 2'd1;
         gdata = op_b;
      end
      gclamp = (gdata > 14'd9999) ? 14'd9999 : gdata;
   end

   // One double-dabble iteration: adjust nibbles, then shift
   always_comb begin
      adj = sreg[29:14];
      for (int i = 0; i < 4; i++) begin
         if (adj[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
      step = {adj, sreg[13:0]} << 1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      grant     = 1'b0;
      done      = 1'b0;
      clr       = 3'b000;
      busy      = (state != IDLE);
      unique case (state)
         IDLE: begin
            if (|pend) begin
               grant     = 1'b1;
               clr       = 3'b001 << gsel;
               state_nxt = CONVERT;
            end
         end
         CONVERT: begin
            if (iter == 4'd13) begin
               done      = 1'b1;
               state_nxt = (HOLD_CYCLES == 0) ? IDLE : HOLD;
            end
         end
         HOLD: begin
            if (hold_cnt == 32'd0) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A request arriving on the grant edge survives the clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend      <= 3'b000;
         sreg      <= '0;
         iter      <= 4'd0;
         cur_src   <= 2'd0;
         cur_ovf   <= 1'b0;
         hold_cnt  <= 32'd0;
         bcd_out   <= 16'd0;
         bcd_valid <= 1'b0;
         src_sel   <= 2'd0;
         overflow  <= 1'b0;
      end else begin
         pend <= (pend & ~clr) | {sum_req, op_b_req, op_a_req};
         if (grant) begin
            sreg    <= {16'd0, gclamp};
            iter    <= 4'd0;
            cur_src <= gsel;
            cur_ovf <= (gdata > 14'd9999);
         end else if (state == CONVERT) begin
            sreg <= step;
            iter <= iter + 4'd1;
         end
         if (done) begin
            bcd_out   <= step[29:14];
            src_sel   <= cur_src;
            overflow  <= cur_ovf;
            bcd_valid <= 1'b1;
            hold_cnt  <= HOLD_LOAD;
         end else if (state == HOLD && hold_cnt != 32'd0) begin
            hold_cnt <= hold_cnt - 32'd1;
         end
      end
   end

endmodule
